// File: rtl/vmem_banked_pkg.sv
// Shared definitions for the banked vector local memory: op field layout,
// access pattern encodings and the sequencing states.
package vmem_banked_pkg;

  // op = {memop, pattern[1:0], size[1:0], signed, we}
  localparam int OP_WIDTH  = 7;
  localparam int OP_MEMOP  = 6;
  localparam int OP_PAT_HI = 5;
  localparam int OP_PAT_LO = 4;
  localparam int OP_WE     = 0;

  // Pattern 1x is indexed; only bit 1 is looked at for that case.
  typedef enum logic [1:0] {
    PAT_UNIT   = 2'b00,
    PAT_STRIDE = 2'b01,
    PAT_INDEX  = 2'b10
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic pat_is_index(input logic [1:0] pat);
    return pat[1];
  endfunction

  function automatic logic pat_is_stride(input logic [1:0] pat);
    return (pat == PAT_STRIDE);
  endfunction

endpackage

// File: rtl/vmem_banked_local_if.sv
// Request/completion bundle between the vector memory unit (master) and
// the banked local memory (slave).
interface vmem_banked_local_if #(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 32,
  parameter int VCWIDTH      = 32,
  parameter int OFFSETWIDTH  = 8,
  parameter int AWIDTH       = 14,
  parameter int PCWIDTH      = $clog2(NUMLANES) + 1
);
  logic                             in_valid;
  logic                             in_ready;
  logic [6:0]                       op;
  logic [AWIDTH-1:0]                address;
  logic [VCWIDTH-1:0]               stride_val;
  logic [NUMLANES*OFFSETWIDTH-1:0]  offset;
  logic [NUMLANES-1:0]              en;
  logic [NUMLANES*DATAWORDSIZE-1:0] data_in;
  logic                             out_valid;
  logic [NUMLANES*DATAWORDSIZE-1:0] out_data;
  logic [PCWIDTH-1:0]               pass_count;

  modport master (
    output in_valid, op, address, stride_val, offset, en, data_in,
    input  in_ready, out_valid, out_data, pass_count
  );

  modport slave (
    input  in_valid, op, address, stride_val, offset, en, data_in,
    output in_ready, out_valid, out_data, pass_count
  );
endinterface

// File: rtl/ram_wrapper.sv
// Single-port bank RAM with one-cycle registered read. Contents are not reset.
module ram_wrapper #(
  parameter int AWIDTH    = 11,
  parameter int DWIDTH    = 32,
  parameter int NUM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem_r [NUM_WORDS];
  logic [DWIDTH-1:0] rdata_r;

  // Write or read one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/vmem_bank_arb.sv
// Fixed-priority arbiter for one bank: the lowest-indexed requesting lane wins.
module vmem_bank_arb #(
  parameter int NUMLANES = 8,
  parameter int IDXW     = (NUMLANES > 1) ? $clog2(NUMLANES) : 1
) (
  input  logic [NUMLANES-1:0] req,
  output logic [NUMLANES-1:0] gnt,
  output logic [IDXW-1:0]     idx,
  output logic                any
);
  // Scan upward and keep only the first requester.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUMLANES; i++) begin
      if (req[i] && !any) begin
        gnt[i] = 1'b1;
        idx    = IDXW'(i);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/vmem_banked_local.sv
// Banked vector local memory. Lane addresses are spread over NUMBANKS
// single-port RAMs by the low word-address bits; conflicting lanes are
// serialised over several issue passes, lowest lane first in each bank.
module vmem_banked_local
  import vmem_banked_pkg::*;
#(
  parameter int NUMLANES     = 8,
  parameter int NUMBANKS     = 8,
  parameter int DATAWORDSIZE = 32,
  parameter int VCWIDTH      = 32,
  parameter int MEMDEPTH     = 2048,
  parameter int OFFSETWIDTH  = 8
) (
  input  logic          clk,
  input  logic          resetn,
  vmem_banked_local_if.slave bus
);
  localparam int LOGNUMBANKS = $clog2(NUMBANKS);
  localparam int LOGMEMDEPTH = $clog2(MEMDEPTH);
  localparam int AWIDTH      = LOGMEMDEPTH + LOGNUMBANKS;
  localparam int LOGNUMLANES = (NUMLANES > 1) ? $clog2(NUMLANES) : 1;
  localparam int PCWIDTH     = $clog2(NUMLANES) + 1;
  localparam int DW          = DATAWORDSIZE;

  state_e state_r, state_s;

  // Captured request
  logic [1:0]                 pat_r;
  logic                       we_r;
  logic [AWIDTH-1:0]          base_r;
  logic [AWIDTH-1:0]          stride_r;
  logic [NUMLANES*OFFSETWIDTH-1:0] offset_r;
  logic [NUMLANES*DW-1:0]     data_r;
  logic [NUMLANES-1:0]        pending_r;
  logic [PCWIDTH-1:0]         pass_cnt_r;
  logic [NUMLANES-1:0]        rd_lane_r;
  logic [NUMLANES*DW-1:0]     result_r;

  // Registered outputs
  logic                       out_valid_r;
  logic [NUMLANES*DW-1:0]     out_data_r;
  logic [PCWIDTH-1:0]         pass_count_r;

  // Per-lane and per-bank combinational signals
  logic [AWIDTH-1:0]          lane_addr_s [NUMLANES];
  logic [LOGNUMBANKS-1:0]     lane_bank_s [NUMLANES];
  logic [LOGMEMDEPTH-1:0]     lane_row_s  [NUMLANES];
  logic [NUMLANES-1:0]        req_s       [NUMBANKS];
  logic [NUMLANES-1:0]        gnt_s       [NUMBANKS];
  logic [LOGNUMLANES-1:0]     gnt_idx_s   [NUMBANKS];
  logic                       gnt_any_s   [NUMBANKS];
  logic                       bank_en_s   [NUMBANKS];
  logic [LOGMEMDEPTH-1:0]     bank_row_s  [NUMBANKS];
  logic [DW-1:0]              bank_wdata_s[NUMBANKS];
  logic [DW-1:0]              bank_rdata_s[NUMBANKS];
  logic [NUMLANES-1:0]        granted_s;
  logic [NUMLANES-1:0]        pending_next_s;
  logic [NUMLANES*DW-1:0]     result_next_s;
  logic                       accept_s;

  assign accept_s     = bus.in_valid && (state_r == ST_IDLE);
  assign bus.in_ready = (state_r == ST_IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.pass_count = pass_count_r;

  // Per-lane word address (modulo 2^AWIDTH) and its bank/row split.
  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      lane_addr_s[i] = '0;
      if (pat_is_index(pat_r)) begin
        lane_addr_s[i] = base_r + AWIDTH'(offset_r[i*OFFSETWIDTH +: OFFSETWIDTH]);
      end else if (pat_is_stride(pat_r)) begin
        lane_addr_s[i] = base_r + AWIDTH'(i) * stride_r;
      end else begin
        lane_addr_s[i] = base_r + AWIDTH'(i);
      end
      lane_bank_s[i] = lane_addr_s[i][LOGNUMBANKS-1:0];
      lane_row_s[i]  = lane_addr_s[i][AWIDTH-1:LOGNUMBANKS];
    end
  end

  // Pending lanes that target each bank.
  always_comb begin
    for (int b = 0; b < NUMBANKS; b++) begin
      req_s[b] = '0;
      for (int i = 0; i < NUMLANES; i++) begin
        req_s[b][i] = pending_r[i] && (lane_bank_s[i] == LOGNUMBANKS'(b));
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < NUMBANKS; gb++) begin : g_bank
      vmem_bank_arb #(.NUMLANES(NUMLANES), .IDXW(LOGNUMLANES)) u_arb (
        .req (req_s[gb]),
        .gnt (gnt_s[gb]),
        .idx (gnt_idx_s[gb]),
        .any (gnt_any_s[gb])
      );

      ram_wrapper #(.AWIDTH(LOGMEMDEPTH), .DWIDTH(DW), .NUM_WORDS(MEMDEPTH)) u_ram (
        .clk   (clk),
        .en    (bank_en_s[gb]),
        .we    (we_r),
        .addr  (bank_row_s[gb]),
        .wdata (bank_wdata_s[gb]),
        .rdata (bank_rdata_s[gb])
      );
    end
  endgenerate

  // Steer each granted lane's row and store data to its bank; collect grants.
  always_comb begin
    granted_s = '0;
    for (int b = 0; b < NUMBANKS; b++) begin
      int lane_idx;
      lane_idx        = int'(gnt_idx_s[b]);
      bank_en_s[b]    = (state_r == ST_ISSUE) && gnt_any_s[b];
      bank_row_s[b]   = lane_row_s[lane_idx];
      bank_wdata_s[b] = data_r[lane_idx*DW +: DW];
      if (state_r == ST_ISSUE) begin
        granted_s = granted_s | gnt_s[b];
      end else begin
        granted_s = granted_s;
      end
    end
    pending_next_s = pending_r & ~granted_s;
  end

  // Merge read data from last cycle's grants into the per-lane result.
  always_comb begin
    result_next_s = result_r;
    for (int i = 0; i < NUMLANES; i++) begin
      if (rd_lane_r[i]) begin
        result_next_s[i*DW +: DW] = bank_rdata_s[lane_bank_s[i]];
      end else begin
        result_next_s[i*DW +: DW] = result_r[i*DW +: DW];
      end
    end
  end

  // Sequencing next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (pending_next_s == '0) state_s = ST_DRAIN;
        else                      state_s = ST_ISSUE;
      end
      ST_DRAIN: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Request capture, pass bookkeeping and read-result accumulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_r      <= 2'b00;
      we_r       <= 1'b0;
      base_r     <= '0;
      stride_r   <= '0;
      offset_r   <= '0;
      data_r     <= '0;
      pending_r  <= '0;
      pass_cnt_r <= '0;
      rd_lane_r  <= '0;
      result_r   <= '0;
    end else if (accept_s) begin
      pat_r      <= bus.op[OP_PAT_HI:OP_PAT_LO];
      we_r       <= bus.op[OP_WE];
      base_r     <= bus.address;
      stride_r   <= bus.stride_val[AWIDTH-1:0];
      offset_r   <= bus.offset;
      data_r     <= bus.data_in;
      pending_r  <= bus.op[OP_MEMOP] ? bus.en : '0;
      pass_cnt_r <= '0;
      rd_lane_r  <= '0;
      result_r   <= '0;
    end else begin
      if (state_r == ST_ISSUE) begin
        pending_r  <= pending_next_s;
        pass_cnt_r <= pass_cnt_r + PCWIDTH'(1);
        rd_lane_r  <= we_r ? '0 : granted_s;
      end else begin
        rd_lane_r  <= '0;
      end
      result_r <= result_next_s;
    end
  end

  // Completion pulse, result and pass count, published out of DRAIN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      pass_count_r <= '0;
    end else begin
      out_valid_r <= (state_r == ST_DRAIN);
      if (state_r == ST_DRAIN) begin
        out_data_r   <= result_next_s;
        pass_count_r <= pass_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_vmem_banked_local.sv
// Bench for vmem_banked_local: directed vector table, a reset-abort
// sequence and randomized requests checked against a word-array model.
module tb_vmem_banked_local;
  localparam int NL = 8;
  localparam int NB = 8;
  localparam int DW = 32;
  localparam int VW = 32;
  localparam int OW = 8;
  localparam int MD = 2048;
  localparam int AW = 14;
  localparam int WORDS = 1 << AW;

  typedef struct {
    logic          memop;
    logic          we;
    logic [1:0]    pat;
    logic [AW-1:0] base;
    logic [31:0]   stride;
    logic [63:0]   off;
    logic [7:0]    en;
    logic [255:0]  data;
  } req_t;

  typedef struct {
    req_t         req;
    int           exp_pass;
    logic [255:0] exp_data;
    logic [7:0]   mask;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_m [WORDS];
  bit          known_m [WORDS];

  vmem_banked_local_if #(.NUMLANES(NL), .DATAWORDSIZE(DW), .VCWIDTH(VW),
                         .OFFSETWIDTH(OW), .AWIDTH(AW)) bus ();

  vmem_banked_local #(.NUMLANES(NL), .NUMBANKS(NB), .DATAWORDSIZE(DW),
                      .VCWIDTH(VW), .MEMDEPTH(MD), .OFFSETWIDTH(OW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lane_addr(input req_t r, input int i);
    longint a;
    if (r.pat[1])      a = longint'(r.base) + longint'(r.off[i*8 +: 8]);
    else if (r.pat[0]) a = longint'(r.base) + longint'(i) * longint'($signed(r.stride));
    else               a = longint'(r.base) + longint'(i);
    a = a % WORDS;
    if (a < 0) a = a + WORDS;
    return int'(a);
  endfunction

  // Passes = the most lanes any single bank has to serve, never less than 1.
  function automatic int model_pass(input req_t r);
    int cnt [NB];
    int mx;
    mx = 1;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    for (int i = 0; i < NL; i++)
      if (r.memop && r.en[i]) cnt[lane_addr(r, i) % NB]++;
    for (int b = 0; b < NB; b++) if (cnt[b] > mx) mx = cnt[b];
    return mx;
  endfunction

  task automatic model_apply(input req_t r);
    if (r.memop && r.we)
      for (int i = 0; i < NL; i++)
        if (r.en[i]) begin
          mem_m[lane_addr(r, i)]   = r.data[i*32 +: 32];
          known_m[lane_addr(r, i)] = 1'b1;
        end
  endtask

  task automatic model_load(input req_t r, output logic [255:0] d, output logic [7:0] m);
    d = '0;
    m = '0;
    for (int i = 0; i < NL; i++) begin
      if (!(r.memop && r.en[i])) begin
        m[i] = 1'b1;
      end else if (known_m[lane_addr(r, i)]) begin
        m[i] = 1'b1;
        d[i*32 +: 32] = mem_m[lane_addr(r, i)];
      end
    end
  endtask

  task automatic drive_accept(input req_t r, output bit ok);
    int w;
    ok = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0");
      return;
    end
    bus.op         = {r.memop, r.pat, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r.we};
    bus.address    = r.base;
    bus.stride_val = r.stride;
    bus.offset     = r.off;
    bus.en         = r.en;
    bus.data_in    = r.data;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic exec_check(input string nm, input req_t r, input int exp_pass,
                            input logic [255:0] exp_data, input logic [7:0] mask);
    bit ok;
    int lat;
    drive_accept(r, ok);
    if (!ok) return;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_pass + 2));
    chk({nm, "_pass"}, 64'(bus.pass_count), 64'(exp_pass));
    if (!r.we)
      for (int i = 0; i < NL; i++)
        if (mask[i]) chk($sformatf("%s_lane%0d", nm, i), 64'(bus.out_data[i*32 +: 32]),
                         64'(exp_data[i*32 +: 32]));
    @(negedge clk);
    chk({nm, "_pulse_end"}, {63'd0, bus.out_valid}, 64'd0);
    model_apply(r);
  endtask

  function automatic req_t mk(input logic memop, input logic we, input logic [1:0] pat,
                              input int base, input logic [31:0] stride, input logic [7:0] en);
    req_t r;
    r.memop = memop; r.we = we; r.pat = pat; r.base = AW'(base);
    r.stride = stride; r.off = '0; r.en = en; r.data = '0;
    return r;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t v;
    req_t r;
    logic [255:0] ed;
    logic [7:0] em;
    int seen;
    bit ok;

    bus.in_valid = 1'b0; bus.op = 7'd0; bus.address = '0; bus.stride_val = 32'd0;
    bus.offset = '0; bus.en = 8'd0; bus.data_in = '0;
    for (int a = 0; a < WORDS; a++) known_m[a] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_pass_count", 64'(bus.pass_count), 64'd0);
    chk("rst_out_data", bus.out_data[63:0] | bus.out_data[255:192], 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 0: unit store at 0, lane i -> 0x100+i
    v.req = mk(1'b1, 1'b1, 2'b00, 0, 32'd0, 8'hFF);
    for (int i = 0; i < NL; i++) v.req.data[i*32 +: 32] = 32'h100 + 32'(i);
    v.exp_pass = 1; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 1: unit load at 0
    v.req = mk(1'b1, 1'b0, 2'b00, 0, 32'd0, 8'hFF);
    for (int i = 0; i < NL; i++) v.exp_data[i*32 +: 32] = 32'h100 + 32'(i);
    v.exp_pass = 1; v.mask = 8'hFF; vecs.push_back(v);
    // 2: stride-8 store, all lanes in bank 0
    v.req = mk(1'b1, 1'b1, 2'b01, 0, 32'd8, 8'hFF);
    for (int i = 0; i < NL; i++) v.req.data[i*32 +: 32] = 32'h200 + 32'(i);
    v.exp_pass = 8; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 3: stride-8 load of words 0,8..56
    v.req = mk(1'b1, 1'b0, 2'b01, 0, 32'd8, 8'hFF);
    for (int i = 0; i < NL; i++) v.exp_data[i*32 +: 32] = 32'h200 + 32'(i);
    v.exp_pass = 8; v.mask = 8'hFF; vecs.push_back(v);
    // 4: indexed store, every lane to word 5, data = lane
    v.req = mk(1'b1, 1'b1, 2'b10, 0, 32'd0, 8'hFF);
    for (int i = 0; i < NL; i++) begin
      v.req.off[i*8 +: 8] = 8'd5;
      v.req.data[i*32 +: 32] = 32'(i);
    end
    v.exp_pass = 8; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 5: unit load at 5: highest lane won word 5
    v.req = mk(1'b1, 1'b0, 2'b00, 5, 32'd0, 8'hFF);
    v.exp_data = '0;
    v.exp_data[31:0] = 32'd7; v.exp_data[63:32] = 32'h106;
    v.exp_data[95:64] = 32'h107; v.exp_data[127:96] = 32'h201;
    v.exp_pass = 1; v.mask = 8'h0F; vecs.push_back(v);
    // 6: stride -1 store from 0, wrapping downward
    v.req = mk(1'b1, 1'b1, 2'b01, 0, 32'hFFFF_FFFF, 8'hFF);
    for (int i = 0; i < NL; i++) v.req.data[i*32 +: 32] = 32'h300 + 32'(i);
    v.exp_pass = 1; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 7: indexed load base WORDS-7, offset i: wraps to word 0 on lane 7
    v.req = mk(1'b1, 1'b0, 2'b11, WORDS - 7, 32'd0, 8'hFF);
    for (int i = 0; i < NL; i++) begin
      v.req.off[i*8 +: 8] = 8'(i);
      v.exp_data[i*32 +: 32] = 32'h307 - 32'(i);
    end
    v.exp_pass = 1; v.mask = 8'hFF; vecs.push_back(v);
    // 8: unit load base WORDS-4 wraps into words 0..3
    v.req = mk(1'b1, 1'b0, 2'b00, WORDS - 4, 32'd0, 8'hFF);
    v.exp_data[31:0] = 32'h304; v.exp_data[63:32] = 32'h303;
    v.exp_data[95:64] = 32'h302; v.exp_data[127:96] = 32'h301;
    v.exp_data[159:128] = 32'h300; v.exp_data[191:160] = 32'h101;
    v.exp_data[223:192] = 32'h102; v.exp_data[255:224] = 32'h103;
    v.exp_pass = 1; v.mask = 8'hFF; vecs.push_back(v);
    // 9: store with no lanes enabled
    v.req = mk(1'b1, 1'b1, 2'b00, 0, 32'd0, 8'h00);
    for (int i = 0; i < NL; i++) v.req.data[i*32 +: 32] = 32'hBAD0 + 32'(i);
    v.exp_pass = 1; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 10: store with memop=0
    v.req = mk(1'b0, 1'b1, 2'b00, 0, 32'd0, 8'hFF);
    for (int i = 0; i < NL; i++) v.req.data[i*32 +: 32] = 32'hDEAD0 + 32'(i);
    v.exp_pass = 1; v.exp_data = '0; v.mask = 8'h00; vecs.push_back(v);
    // 11: partial-enable load; disabled lanes read 0, nothing was overwritten
    v.req = mk(1'b1, 1'b0, 2'b00, 0, 32'd0, 8'h0F);
    v.exp_data = '0;
    v.exp_data[31:0] = 32'h300; v.exp_data[63:32] = 32'h101;
    v.exp_data[95:64] = 32'h102; v.exp_data[127:96] = 32'h103;
    v.exp_pass = 1; v.mask = 8'hFF; vecs.push_back(v);
    // 12: load with memop=0 returns all zero
    v.req = mk(1'b0, 1'b0, 2'b00, 0, 32'd0, 8'hFF);
    v.exp_data = '0; v.exp_pass = 1; v.mask = 8'hFF; vecs.push_back(v);

    foreach (vecs[k])
      exec_check($sformatf("vec%0d", k), vecs[k].req, vecs[k].exp_pass,
                 vecs[k].exp_data, vecs[k].mask);

    // Reset during pass 3 of a stride-8 load
    r = mk(1'b1, 1'b0, 2'b01, 0, 32'd8, 8'hFF);
    drive_accept(r, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_pass_count", 64'(bus.pass_count), 64'd0);
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.out_valid || !bus.in_ready) seen++;
      end
      chk("abort_during_reset", 64'(seen), 64'd0);
      resetn = 1'b1;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("abort_no_pulse", 64'(seen), 64'd0);
    end
    r = mk(1'b1, 1'b0, 2'b00, 0, 32'd0, 8'hFF);
    model_load(r, ed, em);
    exec_check("post_reset_load", r, model_pass(r), ed, em);

    // Randomized store/load pairs around a shared base
    for (int it = 0; it < 40; it++) begin
      int base;
      base = $urandom_range(0, 300);
      r = mk(($urandom_range(0, 9) != 0), 1'b1, 2'($urandom_range(0, 3)), base,
             32'($urandom_range(0, 40)) - 32'd20, 8'($urandom_range(0, 255)));
      for (int i = 0; i < NL; i++) begin
        r.off[i*8 +: 8] = 8'($urandom_range(0, 255));
        r.data[i*32 +: 32] = $urandom;
      end
      exec_check($sformatf("rnd_st%0d", it), r, model_pass(r), '0, 8'h00);
      r.we = 1'b0;
      r.memop = ($urandom_range(0, 9) != 0);
      r.pat = 2'($urandom_range(0, 3));
      r.en = 8'($urandom_range(0, 255));
      model_load(r, ed, em);
      exec_check($sformatf("rnd_ld%0d", it), r, model_pass(r), ed, em);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vmem_banked_local.md
Name: vmem_banked_local

Overview:
- Next-generation vector local memory with parametrised lane count and bank count; each bank is a separate RAM.
- Unit, strided and indexed vector accesses are spread across the banks by word address.
- Bank conflicts are resolved by serialising the access over several issue passes.
- Sits beside the vector lanes and is driven by the vector memory unit through a valid/ready request and a completion pulse.

Parameters:
- NUMLANES, 8, vector lanes per request (power of 2).
- NUMBANKS, 8, RAM banks (power of 2, >= 2).
- DATAWORDSIZE, 32, word width.
- VCWIDTH, 32, stride width, two's complement.
- MEMDEPTH, 2048, words per bank.
- OFFSETWIDTH, 8, per-lane index offset width, unsigned.
- LOGNUMBANKS / LOGMEMDEPTH, $clog2 values, derived.
- AWIDTH, LOGMEMDEPTH+LOGNUMBANKS, word address width, derived.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- op  in  7  {memop, pattern[1:0], size[1:0], signed, we}; size and signed are ignored (word access only).
- address  in  AWIDTH  base word address.
- stride_val  in  VCWIDTH  signed stride, used when pattern==01.
- offset  in  NUMLANES*OFFSETWIDTH  per-lane index offsets.
- en  in  NUMLANES  lane enables.
- data_in  in  NUMLANES*DATAWORDSIZE  store data.
- out_valid  out  1  one-cycle completion pulse.
- out_data  out  NUMLANES*DATAWORDSIZE  load result; held until the next completion.
- pass_count  out  $clog2(NUMLANES)+1  issue passes used; valid with out_valid.

Behaviour:
- Request capture: a request is accepted on in_valid & in_ready (cycle T). All inputs are registered at T.
- Per-lane address i:
  - pattern 00: address+i
  - pattern 01: address+i*stride_val
  - pattern 1x: address+offset[i]
  - All arithmetic is modulo 2^AWIDTH (wrap-around).
- Address split: bank = addr[LOGNUMBANKS-1:0]; row = addr[AWIDTH-1:LOGNUMBANKS].
- Pending mask: initialised to en at T. memop=0 gives an empty mask.
- States:
  - IDLE: wait for accept; accept -> ISSUE.
  - ISSUE: for each bank, the lowest-indexed pending lane targeting it is granted. Granted lanes access the bank this cycle, and their mask bits are cleared. Identical addresses still conflict (no broadcast).
    - ISSUE -> DRAIN when the mask becomes empty after this pass.
    - An empty mask still spends exactly one ISSUE cycle.
  - DRAIN: one cycle; captures the last read data -> DONE.
  - DONE: out_valid=1 for one cycle -> IDLE.
- Latency with P passes: out_valid at T+P+2 for loads and stores alike. P=1 for conflict-free requests. Maximum P = NUMLANES.
- Loads:
  - Bank RAM read latency is 1 cycle.
  - The grant vector is delayed one cycle to steer read data into the per-lane result register.
  - Disabled lanes return 0.
- Stores:
  - Write bank = granted lane's data.
  - Same-address lanes are written in ascending lane order, so the highest enabled lane wins.
- pass_count = number of ISSUE cycles (>= 1).
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, pass_count=0, pending mask=0. RAM contents are not reset.
- Reset mid-operation: returns to IDLE immediately. No out_valid for the aborted request. Writes already issued remain.
- in_valid while busy is ignored; the request must be held until in_ready.

Decomposition:
- Package vmem_banked_pkg:
  - op field bit positions.
  - pattern encodings (UNIT=00, STRIDE=01, INDEX=1x).
  - state enum (IDLE, ISSUE, DRAIN, DONE).
- Sub-module vmem_bank_arb:
  - One instance per bank.
  - Input: pending-mask & lane-hits-this-bank vector.
  - Output: one-hot fixed-priority lowest-index grant plus the granted lane index.
- Banks: existing ram_wrapper with one port, AWIDTH=LOGMEMDEPTH, NUM_WORDS=MEMDEPTH.

Test Plan:
- Unit-stride store, address 0, en=0xFF, data lane i=0x100+i -> out_valid at T+3, pass_count=1. Unit-stride load of address 0 returns 0x100..0x107.
- Stride-8 load, NUMBANKS=8, base 0: all lanes map to bank 0 -> pass_count=8, out_valid at T+10. Data matches the prior writes at words 0,8,...,56.
- Indexed store, offsets all 5, en=0xFF, data lane i=i -> pass_count=8. A subsequent unit load at address 5 returns lane0=7.
- Stride=-1 (0xFFFFFFFF), base 0, store data i: lane i writes word (2^AWIDTH - i) mod 2^AWIDTH. Read back via indexed/unit loads confirms the wrap.
- en=0x00 or memop=0 -> no RAM writes, pass_count=1, out_valid at T+3. en=0x0F load -> lanes 4..7 return 0.
- Assert resetn low during pass 3 of the stride-8 load -> in_ready=1 and out_valid=0 during and after reset, no completion pulse. A new unit load after reset completes at T+3.
